// File: rtl/route_comp_pipe.sv
// route_comp_pipe
// Route-computation stage for one input port of a 3D-torus router.
// Each head (or single) flit gets a minimal output direction, either
// dimension-ordered (XYZ or ZYX) or minimal-adaptive around congested ports.
// Body and tail flits reuse the direction held for their packet.
// One register stage with valid/ready handshake at one flit per cycle.
module route_comp_pipe #(
    parameter int FLIT_SIZE = 64,
    parameter int XSIZE     = 4,
    parameter int YSIZE     = 4,
    parameter int ZSIZE     = 4,
    parameter int XW        = 2,
    parameter int YW        = 2,
    parameter int ZW        = 2,
    parameter int ADAPTIVE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XW-1:0]        cur_x,
    input  logic [YW-1:0]        cur_y,
    input  logic [ZW-1:0]        cur_z,
    input  logic                 order_zyx,
    input  logic [5:0]           congested,
    input  logic [FLIT_SIZE-1:0] in_flit,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [FLIT_SIZE-1:0] out_flit,
    output logic [2:0]           out_dir,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err_seq,
    output logic [15:0]          pkt_cnt
);

    localparam logic [1:0] TYPE_HEAD   = 2'b00;
    localparam logic [1:0] TYPE_BODY   = 2'b01;
    localparam logic [1:0] TYPE_TAIL   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    localparam logic [2:0] DIR_XPOS  = 3'd0;
    localparam logic [2:0] DIR_XNEG  = 3'd1;
    localparam logic [2:0] DIR_YPOS  = 3'd2;
    localparam logic [2:0] DIR_YNEG  = 3'd3;
    localparam logic [2:0] DIR_ZPOS  = 3'd4;
    localparam logic [2:0] DIR_ZNEG  = 3'd5;
    localparam logic [2:0] DIR_EJECT = 3'd6;

    localparam int X_MSB = FLIT_SIZE - 3;
    localparam int Y_MSB = X_MSB - XW;
    localparam int Z_MSB = Y_MSB - YW;

    typedef enum logic {
        IDLE,
        PKT
    } pktState_t;

    pktState_t            state_q;
    logic [2:0]           dirHold_q;
    logic [FLIT_SIZE-1:0] outFlit_q;
    logic [2:0]           outDir_q;
    logic                 outValid_q;
    logic                 errSeq_q;
    logic [15:0]          pktCnt_q;

    logic [1:0]    flitType;
    logic [XW-1:0] dstX;
    logic [YW-1:0] dstY;
    logic [ZW-1:0] dstZ;
    logic [5:0]    prodVec;
    logic [2:0]    dorDir;
    logic [2:0]    adaptDir;
    logic [2:0]    routeDir;
    logic          accept;

    assign flitType = in_flit[FLIT_SIZE-1 -: 2];
    assign dstX     = in_flit[X_MSB -: XW];
    assign dstY     = in_flit[Y_MSB -: YW];
    assign dstZ     = in_flit[Z_MSB -: ZW];

    // Ready depends only on the output register state, never on in_valid.
    assign in_ready = ~outValid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // Per-dimension ring distance and the set of productive directions;
    // a distance of exactly half the ring makes both directions productive.
    always_comb begin
        int dX;
        int dY;
        int dZ;
        dX = int'(dstX) - int'(cur_x);
        if (dX < 0) dX = dX + XSIZE;
        dY = int'(dstY) - int'(cur_y);
        if (dY < 0) dY = dY + YSIZE;
        dZ = int'(dstZ) - int'(cur_z);
        if (dZ < 0) dZ = dZ + ZSIZE;
        prodVec    = '0;
        prodVec[0] = (dX != 0) && (2 * dX <= XSIZE);
        prodVec[1] = (dX != 0) && (2 * dX >= XSIZE);
        prodVec[2] = (dY != 0) && (2 * dY <= YSIZE);
        prodVec[3] = (dY != 0) && (2 * dY >= YSIZE);
        prodVec[4] = (dZ != 0) && (2 * dZ <= ZSIZE);
        prodVec[5] = (dZ != 0) && (2 * dZ >= ZSIZE);
    end

    // Dimension-order choice: first unresolved dimension, POS wins a tie.
    always_comb begin
        dorDir = DIR_EJECT;
        if (!order_zyx) begin
            if      (prodVec[0]) dorDir = DIR_XPOS;
            else if (prodVec[1]) dorDir = DIR_XNEG;
            else if (prodVec[2]) dorDir = DIR_YPOS;
            else if (prodVec[3]) dorDir = DIR_YNEG;
            else if (prodVec[4]) dorDir = DIR_ZPOS;
            else if (prodVec[5]) dorDir = DIR_ZNEG;
        end else begin
            if      (prodVec[4]) dorDir = DIR_ZPOS;
            else if (prodVec[5]) dorDir = DIR_ZNEG;
            else if (prodVec[2]) dorDir = DIR_YPOS;
            else if (prodVec[3]) dorDir = DIR_YNEG;
            else if (prodVec[0]) dorDir = DIR_XPOS;
            else if (prodVec[1]) dorDir = DIR_XNEG;
        end
    end

    // Adaptive choice: first uncongested productive port in priority order,
    // falling back to the dimension-order pick when all are congested.
    always_comb begin
        logic       found;
        logic [2:0] code;
        int         dimIdx;
        adaptDir = dorDir;
        found    = 1'b0;
        code     = DIR_XPOS;
        dimIdx   = 0;
        for (int i = 0; i < 6; i++) begin
            dimIdx = order_zyx ? (2 - i / 2) : (i / 2);
            code   = 3'(2 * dimIdx + i % 2);
            if (!found && prodVec[code] && !congested[code]) begin
                adaptDir = code;
                found    = 1'b1;
            end
        end
    end

    assign routeDir = (ADAPTIVE != 0) ? adaptDir : dorDir;

    // Packet framing FSM with the registered output stage; everything
    // advances only on an accepted transfer, and holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dirHold_q  <= DIR_XPOS;
            outFlit_q  <= '0;
            outDir_q   <= DIR_XPOS;
            outValid_q <= 1'b0;
            errSeq_q   <= 1'b0;
            pktCnt_q   <= '0;
        end else begin
            errSeq_q <= 1'b0;
            if (accept) begin
                outFlit_q  <= in_flit;
                outValid_q <= 1'b1;
                if (flitType == TYPE_HEAD || flitType == TYPE_SINGLE) begin
                    pktCnt_q <= pktCnt_q + 16'd1;
                end
                case (state_q)
                    IDLE: begin
                        case (flitType)
                            TYPE_HEAD: begin
                                outDir_q  <= routeDir;
                                dirHold_q <= routeDir;
                                state_q   <= PKT;
                            end
                            TYPE_SINGLE: begin
                                outDir_q <= routeDir;
                            end
                            default: begin
                                outDir_q <= dirHold_q;
                                errSeq_q <= 1'b1;
                            end
                        endcase
                    end
                    PKT: begin
                        case (flitType)
                            TYPE_BODY: begin
                                outDir_q <= dirHold_q;
                            end
                            TYPE_TAIL: begin
                                outDir_q <= dirHold_q;
                                state_q  <= IDLE;
                            end
                            TYPE_HEAD: begin
                                outDir_q  <= routeDir;
                                dirHold_q <= routeDir;
                                errSeq_q  <= 1'b1;
                            end
                            default: begin
                                outDir_q <= routeDir;
                                errSeq_q <= 1'b1;
                                state_q  <= IDLE;
                            end
                        endcase
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (out_ready) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign out_flit  = outFlit_q;
    assign out_dir   = outDir_q;
    assign out_valid = outValid_q;
    assign err_seq   = errSeq_q;
    assign pkt_cnt   = pktCnt_q;

endmodule

// File: doc/route_comp_pipe.md
# route_comp_pipe

Parametrised, flow-controlled route-computation stage for the 3D-torus router input port. It sits between the input buffer and the switch allocator and computes a minimal output direction from each head flit's destination, selectable as dimension-ordered (XYZ/ZYX) or minimal-adaptive. The direction is held for all flits of the packet, and each flit is registered with valid/ready handshaking at full throughput.

## Interface
Parameters:
- FLIT_SIZE, 64: flit width. Bits [FLIT_SIZE-1:FLIT_SIZE-2] hold the type: 2'b00 head, 2'b01 body, 2'b10 tail, 2'b11 single (head+tail).
- XSIZE / YSIZE / ZSIZE, 4 / 4 / 4: torus ring sizes (each ≥2).
- XW / YW / ZW, 2 / 2 / 2: coordinate widths, ≥ clog2(SIZE).
- ADAPTIVE, 0: 0 selects dimension-order routing; 1 selects minimal-adaptive routing.

Head-flit fields, MSB-first below the type field: dst_x [FLIT_SIZE-3 -: XW], then dst_y (YW bits), then dst_z (ZW bits).

Direction codes: 0 XPOS, 1 XNEG, 2 YPOS, 3 YNEG, 4 ZPOS, 5 ZNEG, 6 EJECT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cur_x / cur_y / cur_z  in  XW/YW/ZW  this router's coordinates (static)
- order_zyx  in  1  0 = X→Y→Z priority, 1 = Z→Y→X; sampled on each head
- congested  in  6  per-port congestion, bit i = direction code i; used only when ADAPTIVE=1
- in_flit  in  FLIT_SIZE  input flit
- in_valid  in  1  in_flit valid
- in_ready  out  1  stage can accept
- out_flit  out  FLIT_SIZE  registered flit
- out_dir  out  3  direction for out_flit
- out_valid  out  1  out_flit/out_dir valid
- out_ready  in  1  downstream accepts
- err_seq  out  1  one-cycle pulse on a packet-framing violation
- pkt_cnt  out  16  count of heads routed, wraps

## Operation
Per-dimension arithmetic, shown for X:
- d = (dst_x − cur_x) mod XSIZE, computed at XW+1 bits: if dst_x < cur_x, d = dst_x + XSIZE − cur_x.
- d = 0: the dimension is resolved.
- 0 < d < XSIZE/2: productive direction is POS only.
- d > XSIZE/2: productive direction is NEG only.
- d = XSIZE/2 with even XSIZE (tie): POS and NEG are both productive.

Dimension-order routing (ADAPTIVE=0):
- Take the first unresolved dimension in priority order (XYZ, or ZYX when order_zyx=1).
- Use its productive direction; on a tie, use POS.
- If all three dimensions are resolved, use EJECT.

Minimal-adaptive routing (ADAPTIVE=1):
- Candidates are all productive directions of all unresolved dimensions.
- Scan in priority order, POS before NEG within a dimension, and pick the first candidate with congested=0.
- If every candidate is congested, fall back to the dimension-order choice.
- EJECT ignores congested.

Packet FSM:
- IDLE: head → store dir in dir_hold, go to PKT. Single → route the flit, stay IDLE. Body or tail → forward with out_dir = dir_hold, pulse err_seq, stay IDLE.
- PKT: body → forward with dir_hold. Tail → forward with dir_hold, go to IDLE. Head or single → route it as a new packet, pulse err_seq; head → stay PKT, single → go to IDLE.
- The FSM and dir_hold advance only on an accepted transfer (in_valid & in_ready).
- pkt_cnt increments on every accepted head or single.

## Timing
- Reset values: out_valid=0, out_dir=0, out_flit=0, err_seq=0, pkt_cnt=0, FSM=IDLE, dir_hold=0.
- in_ready = ~out_valid | out_ready (combinational); no combinational path from in_valid to in_ready.
- On acceptance, out_flit/out_dir load at the next edge: latency 1 cycle, throughput 1 flit per cycle.
- While out_valid=1 and out_ready=0: out_flit and out_dir hold stable and in_ready=0.
- congested and order_zyx are sampled in the acceptance cycle only.
- err_seq is asserted in the cycle after the offending flit is accepted, for one cycle.
- rst mid-packet: the next cycle has out_valid=0 and FSM=IDLE; any partial packet is discarded.

## Test plan
- 4×4×4 torus, cur=(0,0,0), ADAPTIVE=0: head dst=(1,0,0) → XPOS; (3,0,0) → XNEG; (2,0,0) tie → XPOS; (0,0,0) → EJECT; each out_valid 1 cycle after accept.
- Packet head(dst (0,3,1)) + 2 body + tail, streaming with out_ready=1: four consecutive outputs, all out_dir=3 (YNEG); pkt_cnt=1.
- order_zyx=1, dst=(1,0,1) → ZPOS; order_zyx=0 → XPOS.
- ADAPTIVE=1, dst=(1,1,0), congested=6'b000001 → YPOS; congested=6'b000101 → XPOS (fallback).
- out_ready held 0 for 3 cycles mid-packet: out_flit stable, in_ready=0, no flit lost or duplicated after release.
- Body flit in IDLE → err_seq pulse, out_dir=dir_hold. rst during body → out_valid=0 next cycle; following head routed normally.
